// File: rtl/cndm_msi_irq_sched.sv
// Round-robin MSI scheduler for the PCIe hard block cfg_interrupt_msi_* port.
// Define CNDM_MSI_STATS_EN to build the stat_sent/stat_fail counters.
module cndm_msi_irq_sched #(
    parameter int IRQ_N     = 32,
    parameter int FUNC_NUM  = 0,
    parameter int TIMEOUT   = 1024,
    parameter int RETRY_DLY = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IRQ_N-1:0] irq_req,
    output logic [IRQ_N-1:0] irq_pending,
    output logic             busy,
    input  logic [3:0]       cfg_interrupt_msi_enable,
    input  logic [11:0]      cfg_interrupt_msi_mmenable,
    output logic [31:0]      cfg_interrupt_msi_int,
    input  logic             cfg_interrupt_msi_sent,
    input  logic             cfg_interrupt_msi_fail,
    output logic [1:0]       cfg_interrupt_msi_select,
    output logic [7:0]       cfg_interrupt_msi_function_number,
    output logic [31:0]      stat_sent,
    output logic [31:0]      stat_fail
);

    localparam int IW = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        BACKOFF
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic [4:0]      vec;
    logic [31:0]     timer;
    logic [31:0]     bcnt;

    logic            msi_en;
    logic [IW-1:0]   pick;
    logic [4:0]      pick_vec;
    logic [2:0]      mme_sh;
    logic [31:0]     mask;
    logic [31:0]     j;
    logic [IRQ_N-1:0] clr_vec;
    logic [IRQ_N-1:0] set_vec;
    logic [IW-1:0]   rr_next;
    logic            ev_sent;
    logic            ev_fail;
    logic            bo_done;
    logic            unused_ok;

    assign msi_en    = cfg_interrupt_msi_enable[0];
    assign unused_ok = ^{cfg_interrupt_msi_enable[3:1],
                         cfg_interrupt_msi_mmenable[11:3]};

    // first pending source at or after rr_ptr, wrapping
    always_comb begin
        pick = '0;
        j    = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            j = (32'(rr_ptr) + 32'(i)) % 32'(IRQ_N);
            if (irq_pending[IW'(j)]) pick = IW'(j);
        end
    end

    always_comb begin
        mme_sh   = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ?
                   3'd5 : cfg_interrupt_msi_mmenable[2:0];
        mask     = (32'd1 << mme_sh) - 32'd1;
        pick_vec = 5'(32'(pick) & mask);
    end

    assign rr_next = (grant == IW'(IRQ_N - 1)) ? '0 : grant + IW'(1);
    assign bo_done = (bcnt == 32'(RETRY_DLY - 1));
    assign ev_sent = (state == WAIT) && cfg_interrupt_msi_sent;
    assign ev_fail = (state == WAIT) && !cfg_interrupt_msi_sent &&
                     (cfg_interrupt_msi_fail || timer == 32'(TIMEOUT - 1));

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (state == IDLE && msi_en && |irq_pending)
            clr_vec = IRQ_N'(1) << pick;
        if (state == BACKOFF && bo_done && !msi_en)
            set_vec = IRQ_N'(1) << grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            irq_pending           <= '0;
            rr_ptr                <= '0;
            grant                 <= '0;
            vec                   <= '0;
            timer                 <= '0;
            bcnt                  <= '0;
            cfg_interrupt_msi_int <= '0;
        end else begin
            // a new request always wins over the grant clear
            irq_pending           <= (irq_pending & ~clr_vec) | irq_req | set_vec;
            cfg_interrupt_msi_int <= '0;
            unique case (state)
                IDLE: begin
                    if (msi_en && |irq_pending) begin
                        grant <= pick;
                        vec   <= pick_vec;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cfg_interrupt_msi_int <= 32'd1 << vec;
                    timer                 <= '0;
                    state                 <= WAIT;
                end
                WAIT: begin
                    if (ev_sent) begin
                        rr_ptr <= rr_next;
                        state  <= IDLE;
                    end else if (ev_fail) begin
                        bcnt  <= '0;
                        state <= BACKOFF;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                BACKOFF: begin
                    if (bo_done)
                        state <= msi_en ? ISSUE : IDLE;
                    else
                        bcnt <= bcnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                              = (state != IDLE);
    assign cfg_interrupt_msi_select          = 2'b00;
    assign cfg_interrupt_msi_function_number = 8'(FUNC_NUM);

`ifdef CNDM_MSI_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent <= '0;
            stat_fail <= '0;
        end else begin
            if (ev_sent) stat_sent <= stat_sent + 32'd1;
            if (ev_fail) stat_fail <= stat_fail + 32'd1;
        end
    end
`else
    assign stat_sent = '0;
    assign stat_fail = '0;
`endif

endmodule

// File: tb/tb_cndm_msi_irq_sched.sv
// Scoreboard bench for cndm_msi_irq_sched: directed requests, responder
// model for sent/fail, monitor comparing every MSI pulse against a queue.
module tb_cndm_msi_irq_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq_req;
    logic [31:0] irq_pending;
    logic        busy;
    logic [3:0]  en;
    logic [11:0] mme;
    logic [31:0] msi_int;
    logic        sent;
    logic        fail;
    logic [1:0]  sel;
    logic [7:0]  fn;
    logic [31:0] stat_sent;
    logic [31:0] stat_fail;

    always #5 clk = ~clk;

    cndm_msi_irq_sched dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .irq_req                           (irq_req),
        .irq_pending                       (irq_pending),
        .busy                              (busy),
        .cfg_interrupt_msi_enable          (en),
        .cfg_interrupt_msi_mmenable        (mme),
        .cfg_interrupt_msi_int             (msi_int),
        .cfg_interrupt_msi_sent            (sent),
        .cfg_interrupt_msi_fail            (fail),
        .cfg_interrupt_msi_select          (sel),
        .cfg_interrupt_msi_function_number (fn),
        .stat_sent                         (stat_sent),
        .stat_fail                         (stat_fail)
    );

    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   resp_mode = 0;
    int   resp_dly = 2;
    int   fail_cnt = 0;
    int   exp_sent = 0;
    int   exp_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int st(input int n);
`ifdef CNDM_MSI_STATS_EN
        st = n;
`else
        st = n & 0;
`endif
    endfunction

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (msi_int != 32'd0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msi got %h expected none", msi_int);
                end else begin
                    e = sb.pop_front();
                    chk("msi_vec", 64'(msi_int), 64'(e.v));
                    if (e.c >= 0) chk("msi_cycle", 64'(cyc), 64'(e.c));
                end
            end
        end
    end

    // PCIe core responder
    initial begin
        forever begin
            @(negedge clk);
            if (msi_int != 32'd0 && resp_mode != 0) begin
                repeat (resp_dly - 1) @(negedge clk);
                if (fail_cnt > 0) begin
                    fail = 1'b1;
                    fail_cnt--;
                end else begin
                    sent = 1'b1;
                end
                @(negedge clk);
                sent = 1'b0;
                fail = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic pulse(input logic [31:0] m, output int k);
        @(negedge clk);
        irq_req = m;
        @(negedge clk);
        irq_req = '0;
        k = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((busy || (en[0] && irq_pending != 0)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s got busy expected idle", name);
        end
    endtask

    initial begin
        int k;
        int m;
        rst_n   = 1'b0;
        irq_req = '0;
        sent    = 1'b0;
        fail    = 1'b0;
        en      = 4'h0;
        mme     = 12'h0;
        repeat (3) @(negedge clk);
        chk("rst_pending", 64'(irq_pending), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_msi", 64'(msi_int), 0);
        chk("rst_sel", 64'(sel), 0);
        chk("rst_fn", 64'(fn), 0);
        chk("rst_stat_sent", 64'(stat_sent), 0);
        chk("rst_stat_fail", 64'(stat_fail), 0);

        rst_n     = 1'b1;
        en        = 4'h1;
        mme       = 12'd5;
        resp_mode = 1;
        resp_dly  = 2;

        // round robin 0,5,9 then wrap from 10: 0 then 9
        pulse(32'h221, k);
        sb.push_back('{32'h1, k + 2});
        sb.push_back('{32'h20, k + 6});
        sb.push_back('{32'h200, k + 10});
        exp_sent += 3;
        wait_idle("rr1");
        chk("rr1_pending", 64'(irq_pending), 0);
        pulse(32'h201, k);
        sb.push_back('{32'h1, k + 2});
        sb.push_back('{32'h200, k + 6});
        exp_sent += 2;
        wait_idle("rr2");
        chk("rr2_stat_sent", 64'(stat_sent), 64'(st(exp_sent)));

        // single source, sent 5 cycles after the pulse
        resp_dly = 5;
        pulse(32'h8, k);
        sb.push_back('{32'h8, k + 2});
        exp_sent++;
        wait_idle("single");
        chk("single_pending", 64'(irq_pending), 0);
        chk("single_busy", 64'(busy), 0);
        chk("single_stat_sent", 64'(stat_sent), 64'(st(exp_sent)));

        // fail then retry after backoff
        resp_dly = 2;
        fail_cnt = 1;
        pulse(32'h80, k);
        sb.push_back('{32'h80, k + 2});
        sb.push_back('{32'h80, k + 21});
        exp_sent++;
        exp_fail++;
        wait_idle("retry");
        chk("retry_stat_fail", 64'(stat_fail), 64'(st(exp_fail)));
        chk("retry_stat_sent", 64'(stat_sent), 64'(st(exp_sent)));

        // mme=2 mapping, coalesced pulses of irq 4
        mme      = 12'd2;
        resp_dly = 10;
        pulse(32'h2000, k);
        sb.push_back('{32'h2, k + 2});
        for (int i = 0; i < 3; i++) pulse(32'h10, m);
        sb.push_back('{32'h1, -1});
        exp_sent += 2;
        wait_idle("coalesce");
        chk("coalesce_pending", 64'(irq_pending), 0);

        // timeout, then disable during backoff
        mme       = 12'd5;
        resp_mode = 0;
        pulse(32'h100000, k);
        sb.push_back('{32'h100000, k + 2});
        repeat (1025) @(negedge clk);
        chk("to_before_stat_fail", 64'(stat_fail), 64'(st(exp_fail)));
        @(negedge clk);
        exp_fail++;
        chk("to_at_stat_fail", 64'(stat_fail), 64'(st(exp_fail)));
        chk("to_busy", 64'(busy), 1);
        repeat (2) @(negedge clk);
        en = 4'h0;
        repeat (19) @(negedge clk);
        chk("to_idle", 64'(busy), 0);
        chk("to_repend", 64'(irq_pending), 64'(32'h100000));
        resp_mode = 1;
        resp_dly  = 2;
        sb.push_back('{32'h100000, -1});
        exp_sent++;
        en = 4'h1;
        wait_idle("reenable");
        chk("reen_pending", 64'(irq_pending), 0);
        chk("reen_stat_sent", 64'(stat_sent), 64'(st(exp_sent)));

        // async reset while waiting for sent
        resp_mode = 0;
        pulse(32'h4, k);
        sb.push_back('{32'h4, k + 2});
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_msi", 64'(msi_int), 0);
        chk("arst_pending", 64'(irq_pending), 0);
        chk("arst_stat_sent", 64'(stat_sent), 0);
        chk("arst_stat_fail", 64'(stat_fail), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", 64'(busy), 0);
        chk("stray_stat_sent", 64'(stat_sent), 0);

        // MSI disabled at boot
        rst_n = 1'b0;
        en    = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse(32'h42, k);
        repeat (10) @(negedge clk);
        chk("dis_pending", 64'(irq_pending), 64'(32'h42));
        chk("dis_busy", 64'(busy), 0);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
